eth_tlptap_arb: RTL

Packet-granular arbiter that shares one tap FIFO write port between NPORT TLP tap sources, for example the RX and TX Eth+IP+UDP+TLP taps.
- Each source writes 74-bit beats {tkeep[7:0], tdata[63:0], tlast, tuser} into a private commit/rollback packet buffer.
- Complete packets are forwarded round-robin to the shared FIFO, never interleaved.
- On overflow a packet is dropped whole, so the downstream FIFO never holds a truncated packet.
- Tap sources' full inputs are tied 0 at top level; all overflow handling is internal.

---
 rtl/eth_tlptap_pkg.sv | 19 +
 rtl/eth_tlptap_pktbuf.sv | 69 ++++++
 rtl/eth_tlptap_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/eth_tlptap_pkg.sv
// Shared beat layout, field positions and arbiter state for the TLP tap arbiter.
package eth_tlptap_pkg;

  localparam int unsigned TAP_W     = 74;
  localparam int unsigned TUSER_BIT = 0;
  localparam int unsigned TLAST_BIT = 1;
  localparam int unsigned DATA_LSB  = 2;
  localparam int unsigned KEEP_LSB  = 66;

  typedef struct packed {
    logic [7:0]  keep;
    logic [63:0] data;
    logic        last;
    logic        user;
  } tap_beat_t;

  typedef enum logic {IDLE, XFER} arb_state_e;

endpackage

// File: rtl/eth_tlptap_pktbuf.sv
// Per-source commit/rollback packet buffer: only whole packets become visible to the reader,
// and a packet that overflows is discarded entirely (DROP mode swallows its remaining beats).
module eth_tlptap_pktbuf
  import eth_tlptap_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned TAP_W = eth_tlptap_pkg::TAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [TAP_W-1:0] i_din,
  input  logic             i_rd_en,
  output logic             o_ready,
  output logic [TAP_W-1:0] o_head,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [TAP_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_cptr, r_rptr, r_pkt_cnt;
  logic             r_dropping, r_drop;
  logic             w_last, w_free, w_store, w_ovf, w_commit, w_rd_last;

  assign w_last    = i_din[TLAST_BIT];
  assign w_free    = (r_wptr - r_rptr) < (AW+1)'(DEPTH);
  assign w_store   = i_wr_en && !r_dropping && w_free;
  assign w_ovf     = i_wr_en && !r_dropping && !w_free;
  assign w_commit  = w_store && w_last;
  assign w_rd_last = i_rd_en && o_head[TLAST_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_cptr     <= '0;
      r_rptr     <= '0;
      r_pkt_cnt  <= '0;
      r_dropping <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= w_ovf;
      if (w_store) begin
        r_wptr <= r_wptr + 1'b1;
        if (w_last) r_cptr <= r_wptr + 1'b1;
      end else if (w_ovf) begin
        // Roll back to the last committed packet; keep discarding until its tlast.
        r_wptr <= r_cptr;
        if (!w_last) r_dropping <= 1'b1;
      end
      if (r_dropping && i_wr_en && w_last) r_dropping <= 1'b0;
      if (i_rd_en) r_rptr <= r_rptr + 1'b1;
      if (w_commit && !w_rd_last) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end else if (!w_commit && w_rd_last) begin
        r_pkt_cnt <= r_pkt_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_ready = (r_pkt_cnt != '0);
  assign o_drop  = r_drop;

endmodule

// File: rtl/eth_tlptap_arb.sv
// Round-robin, packet-granular arbiter merging NPORT tap sources into one FIFO write port.
// Optional per-port packet/drop counters are enabled by defining TLPTAP_ARB_STATS_EN.
module eth_tlptap_arb
  import eth_tlptap_pkg::*;
#(
  parameter int unsigned NPORT = 2,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned TAP_W = eth_tlptap_pkg::TAP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       s_wr_en,
  input  logic [NPORT*TAP_W-1:0] s_din,
  output logic [NPORT-1:0]       s_drop,
  output logic                   m_wr_en,
  output logic [TAP_W-1:0]       m_din,
  input  logic                   m_full,
  output logic [NPORT*32-1:0]    pkt_cnt_o,
  output logic [NPORT*32-1:0]    drop_cnt_o
);

  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [TAP_W-1:0] w_head [NPORT];
  logic [NPORT-1:0] w_ready, w_rd_en;
  arb_state_e       r_state, w_state_d;
  logic [PW-1:0]    r_gnt, w_gnt_d, r_rr, w_rr_d, w_pick;
  logic             w_found;
  int unsigned      w_idx;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    eth_tlptap_pktbuf #(
      .DEPTH(DEPTH),
      .TAP_W(TAP_W)
    ) u_buf (
      .clk    (clk),
      .rst    (rst),
      .i_wr_en(s_wr_en[gi]),
      .i_din  (s_din[gi*TAP_W +: TAP_W]),
      .i_rd_en(w_rd_en[gi]),
      .o_ready(w_ready[gi]),
      .o_head (w_head[gi]),
      .o_drop (s_drop[gi])
    );

`ifdef TLPTAP_ARB_STATS_EN
    logic [31:0] r_pkt_cnt, r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pkt_cnt  <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (m_wr_en && (r_gnt == PW'(gi)) && m_din[TLAST_BIT] && (r_pkt_cnt != '1)) begin
          r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
        if (s_drop[gi] && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end

    assign pkt_cnt_o[gi*32 +: 32]  = r_pkt_cnt;
    assign drop_cnt_o[gi*32 +: 32] = r_drop_cnt;
`else
    assign pkt_cnt_o[gi*32 +: 32]  = '0;
    assign drop_cnt_o[gi*32 +: 32] = '0;
`endif
  end

  // First ready port at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr;
    w_idx   = 0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      w_idx = 32'(r_rr) + k;
      if (w_idx >= NPORT) w_idx = w_idx - NPORT;
      if (!w_found && w_ready[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = PW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_rr_d    = r_rr;
    m_wr_en   = 1'b0;
    m_din     = '0;
    w_rd_en   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_d   = w_pick;
          w_state_d = XFER;
        end
      end
      XFER: begin
        m_din          = w_head[r_gnt];
        m_wr_en        = !m_full;
        w_rd_en[r_gnt] = !m_full;
        if (!m_full && w_head[r_gnt][TLAST_BIT]) begin
          w_rr_d    = (r_gnt == PW'(NPORT - 1)) ? '0 : r_gnt + 1'b1;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_rr    <= w_rr_d;
    end
  end

endmodule
